// File: rtl/timeslice_arbiter.sv
// timeslice_arbiter: round-robin arbiter that gives each granted requester a
// time slice of i_quantum cycles (0 means 2^N cycles). When a slice expires
// the grant passes to the next pending requester with no idle cycle, or is
// renewed if nobody else is waiting. A holder that drops its request loses
// the grant at once. All outputs are registered.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_enable       arbitration enable; low releases any grant
//   i_req[R]       request vector
//   i_quantum[N]   slice length in cycles, latched at each new grant
//   o_grant[R]     one-hot grant, zero when idle
//   o_grant_id[W]  index of the granted requester, zero when idle
//   o_grant_valid  a grant is held
//   o_expired      one-cycle pulse after a slice expired
module timeslice_arbiter #(
  parameter int N = 8,
  parameter int R = 4,
  localparam int W = $clog2(R)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_enable,
  input  logic [R-1:0] i_req,
  input  logic [N-1:0] i_quantum,
  output logic [R-1:0] o_grant,
  output logic [W-1:0] o_grant_id,
  output logic         o_grant_valid,
  output logic         o_expired
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] ptr, ptr_n;
  logic [N-1:0] s_cnt, s_n;
  logic [N-1:0] q_val, q_n;
  logic [R-1:0] grant_n;
  logic [W-1:0] id_n;
  logic         valid_n;
  logic         exp_n;

  logic [R-1:0] mask;
  logic         rr_found;
  logic [W-1:0] rr_id;
  logic [W-1:0] rr_idx;
  logic         expire;
  logic         take;

  // Round-robin search from ptr. While a grant is held the holder is masked,
  // so the same search serves expiry handover and drop handover.
  always_comb begin
    mask     = i_req;
    rr_found = 1'b0;
    rr_id    = '0;
    rr_idx   = '0;
    if (state == GRANT) mask[o_grant_id] = 1'b0;
    for (int unsigned i = 0; i < unsigned'(R); i++) begin
      rr_idx = W'((32'(ptr) + i) % unsigned'(R));
      if (!rr_found && mask[rr_idx]) begin
        rr_found = 1'b1;
        rr_id    = rr_idx;
      end
    end
  end

  // N-bit wrap: q_val == 0 expires at s_cnt == 2^N-1.
  assign expire = (s_cnt == N'(q_val - 1'b1));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    s_n     = s_cnt;
    q_n     = q_val;
    grant_n = o_grant;
    id_n    = o_grant_id;
    valid_n = o_grant_valid;
    exp_n   = 1'b0;
    take    = 1'b0;

    case (state)
      IDLE: begin
        if (i_enable && rr_found) take = 1'b1;
      end
      GRANT: begin
        if (!i_enable) begin
          state_n = IDLE;
          grant_n = '0;
          id_n    = '0;
          valid_n = 1'b0;
          s_n     = '0;
        end else if (!i_req[o_grant_id]) begin
          exp_n = expire;
          if (rr_found) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
            valid_n = 1'b0;
            s_n     = '0;
          end
        end else if (expire) begin
          exp_n = 1'b1;
          if (rr_found) begin
            take = 1'b1;
          end else begin
            s_n = '0;
            q_n = i_quantum;
          end
        end else begin
          s_n = s_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      state_n        = GRANT;
      grant_n        = '0;
      grant_n[rr_id] = 1'b1;
      id_n           = rr_id;
      valid_n        = 1'b1;
      ptr_n          = (rr_id == W'(R - 1)) ? '0 : rr_id + 1'b1;
      q_n            = i_quantum;
      s_n            = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      ptr           <= '0;
      s_cnt         <= '0;
      q_val         <= '0;
      o_grant       <= '0;
      o_grant_id    <= '0;
      o_grant_valid <= 1'b0;
      o_expired     <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      s_cnt         <= s_n;
      q_val         <= q_n;
      o_grant       <= grant_n;
      o_grant_id    <= id_n;
      o_grant_valid <= valid_n;
      o_expired     <= exp_n;
    end
  end

endmodule

// File: tb/tb_timeslice_arbiter.sv
// Directed testbench for timeslice_arbiter (N=8, R=4). Outputs are sampled
// 1 time unit after each rising edge; "cycle k" is the value seen after the
// k-th edge following a stimulus change.
module tb_timeslice_arbiter;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic [3:0] i_req;
  logic [7:0] i_quantum;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic       o_grant_valid;
  logic       o_expired;

  int passed = 0;
  int total  = 0;
  int errors = 0;

  timeslice_arbiter #(.N(8), .R(4)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_req         (i_req),
    .i_quantum     (i_quantum),
    .o_grant       (o_grant),
    .o_grant_id    (o_grant_id),
    .o_grant_valid (o_grant_valid),
    .o_expired     (o_expired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_req   = '0;
    i_reset = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
  endtask

  int first_exp;

  initial begin
    i_reset   = 1'b0;
    i_enable  = 1'b1;
    i_req     = '0;
    i_quantum = 8'd3;
    tick();
    tick();
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_id", 32'(o_grant_id), 32'h0);
    chk("rst_valid", 32'(o_grant_valid), 32'h0);
    chk("rst_expired", 32'(o_expired), 32'h0);
    i_reset = 1'b1;

    // Single requester, Q=3: expiries at cycles 4,7,10, grant never drops
    i_req     = 4'b0001;
    i_quantum = 8'd3;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk("q3_grant", 32'(o_grant), 32'h1);
      chk("q3_valid", 32'(o_grant_valid), 32'h1);
      chk("q3_expired", 32'(o_expired), 32'(c == 4 || c == 7 || c == 10));
    end

    // All requesting, Q=2: order 0,1,2,3,0 two cycles each
    do_reset();
    i_req     = 4'b1111;
    i_quantum = 8'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("rr_grant", 32'(o_grant), 32'(4'b0001 << (((c - 1) / 2) % 4)));
      chk("rr_id", 32'(o_grant_id), 32'(((c - 1) / 2) % 4));
      chk("rr_expired", 32'(o_expired), 32'(c >= 3 && (c % 2) == 1));
    end

    // Q=5, holder 0 drops after 2 cycles with 2 pending
    do_reset();
    i_req     = 4'b0001;
    i_quantum = 8'd5;
    tick();
    tick();
    chk("drop_pre", 32'(o_grant), 32'h1);
    i_req = 4'b0100;
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (c == 3) i_quantum = 8'd7;  // must not shorten/lengthen current slice
      chk("drop_grant", 32'(o_grant), 32'h4);
      chk("drop_expired", 32'(o_expired), 32'(c == 8));
    end

    // Q=0 means 256 cycles
    do_reset();
    i_req     = 4'b0001;
    i_quantum = 8'd0;
    first_exp = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (o_expired && first_exp == 0) first_exp = c;
    end
    chk("q0_first_expiry", 32'(first_exp), 32'd257);
    chk("q0_grant", 32'(o_grant), 32'h1);

    // Enable low mid-slice, then resume after last holder
    do_reset();
    i_req     = 4'b0001;
    i_quantum = 8'd5;
    tick();
    chk("en_first", 32'(o_grant), 32'h1);
    i_enable = 1'b0;
    i_req    = 4'b0111;
    tick();
    chk("en_off_grant", 32'(o_grant), 32'h0);
    chk("en_off_valid", 32'(o_grant_valid), 32'h0);
    chk("en_off_id", 32'(o_grant_id), 32'h0);
    chk("en_off_expired", 32'(o_expired), 32'h0);
    tick();
    chk("en_off_hold", 32'(o_grant), 32'h0);
    i_enable = 1'b1;
    tick();
    chk("en_resume_grant", 32'(o_grant), 32'h2);
    chk("en_resume_id", 32'(o_grant_id), 32'h1);

    // Asynchronous reset mid-slice between edges
    #3;
    i_reset = 1'b0;
    #1;
    chk("arst_grant", 32'(o_grant), 32'h0);
    chk("arst_valid", 32'(o_grant_valid), 32'h0);
    chk("arst_id", 32'(o_grant_id), 32'h0);
    i_quantum = 8'd1;
    i_req     = 4'b1000;
    #2;
    i_reset = 1'b1;
    tick();
    chk("arst_post_grant", 32'(o_grant), 32'h8);
    chk("arst_post_id", 32'(o_grant_id), 32'h3);
    chk("arst_post_expired", 32'(o_expired), 32'h0);
    i_req = 4'b1111;
    tick();
    chk("arst_wrap_grant", 32'(o_grant), 32'h1);
    chk("arst_wrap_expired", 32'(o_expired), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
